// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM state encoding, the
// 256-bit packed trace record, its field offsets and the record packer.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  // Field offsets inside a packed record (LSB positions)
  localparam int PC_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int WDATA_LSB = 64;
  localparam int RD_LSB    = 96;
  localparam int WE_BIT    = 101;
  localparam int TS_LSB    = 128;
  localparam int ENTRY_W   = 256;

  // Declared MSB first so that pc lands on bits [31:0]
  typedef struct packed {
    logic [95:0] rsvd_hi;    // [255:160]
    logic [31:0] timestamp;  // [159:128]
    logic [25:0] rsvd_mid;   // [127:102]
    logic        we;         // [101]
    logic [4:0]  rd;         // [100:96]
    logic [31:0] wdata;      // [95:64]
    logic [31:0] instr;      // [63:32]
    logic [31:0] pc;         // [31:0]
  } trace_entry_t;

  // Build a record; wdata is forced to zero when no register write happened
  function automatic trace_entry_t pack_entry(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [4:0]  rd,
    input logic        we,
    input logic [31:0] wdata,
    input logic [31:0] ts
  );
    trace_entry_t e;
    e           = '0;
    e.pc        = pc;
    e.instr     = instr;
    e.wdata     = we ? wdata : 32'h0000_0000;
    e.rd        = rd;
    e.we        = we;
    e.timestamp = ts;
    return e;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port record store: one synchronous write port, one synchronous
// read port with a resettable output register (maps onto block RAM).
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port: storage array has no reset, contents are tracked by count
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: output register cleared by reset, updated only on a read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Circular capture buffer for retired-instruction records. Keeps pre-trigger
// history, captures POST_DEPTH records after a PC-match trigger, freezes, and
// then drains oldest-first as 256-bit packed records.
// Optional feature: define TRACE_TIMESTAMP_EN to stamp each record with a
// free-running 32-bit cycle counter; otherwise the timestamp field is zero.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int POST_DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     commit_valid_i,
  input  logic [31:0]              commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic [4:0]               commit_rd_i,
  input  logic                     commit_we_i,
  input  logic [31:0]              commit_wdata_i,
  input  logic                     arm_i,
  input  logic                     disarm_i,
  input  logic [31:0]              trig_pc_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [255:0]             rd_data_o,
  output logic                     rd_empty_o,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_cnt_q, post_cnt_d;
  logic [CW-1:0] unread_q, unread_d;
  logic          rd_valid_q;
  logic          rd_empty_q;
  logic          wr_en_s;
  logic          rd_acc_s;
  logic          freeze_s;
  logic [31:0]   ts_s;
  trace_entry_t  entry_s;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  assign ts_s = ts_q;
`else
  assign ts_s = 32'd0;
`endif

  assign entry_s = pack_entry(commit_pc_i, commit_instr_i, commit_rd_i,
                              commit_we_i, commit_wdata_i, ts_s);

  // Capture/drain FSM next state; arm beats disarm beats trigger/commit
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    unread_d   = unread_q;
    wr_en_s    = 1'b0;
    rd_acc_s   = 1'b0;
    freeze_s   = 1'b0;
    if (arm_i) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      unread_d   = '0;
    end else if (disarm_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (commit_valid_i) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            // Saturate at DEPTH: once full the oldest record is overwritten
            if (count_q != CW'(DEPTH)) begin
              count_d = count_q + CW'(1);
            end else begin
              count_d = count_q;
            end
            if (state_q == ARMED) begin
              if (commit_pc_i == trig_pc_i) begin
                if (POST_DEPTH == 0) begin
                  freeze_s = 1'b1;
                end else begin
                  state_d    = POST;
                  post_cnt_d = CW'(POST_DEPTH);
                end
              end else begin
                state_d = ARMED;
              end
            end else begin
              post_cnt_d = post_cnt_q - CW'(1);
              if (post_cnt_q == CW'(1)) begin
                freeze_s = 1'b1;
              end else begin
                state_d = POST;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        FROZEN: begin
          if (rd_en_i && (unread_q != '0)) begin
            rd_acc_s = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            unread_d = unread_q - CW'(1);
          end else begin
            rd_acc_s = 1'b0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
      // Oldest record sits count entries behind the write pointer
      if (freeze_s) begin
        state_d  = FROZEN;
        rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        unread_d = count_d;
      end else begin
        state_d = state_d;
      end
    end
  end

  // Control and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      unread_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      unread_q   <= unread_d;
      rd_valid_q <= rd_acc_s;
      rd_empty_q <= (unread_d == '0);
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (entry_s),
    .re_i    (rd_acc_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_o)
  );

  assign rd_valid_o = rd_valid_q;
  assign rd_empty_o = rd_empty_q;
  assign state_o    = state_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer. Instance A: DEPTH=8, POST_DEPTH=2.
// Instance B: DEPTH=8, POST_DEPTH=0. Both share the commit bus and reset.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  logic        clk, rst;
  logic        commit_valid, commit_we;
  logic [31:0] commit_pc, commit_instr, commit_wdata;
  logic [4:0]  commit_rd;

  logic        arm_a, disarm_a, rd_en_a, rd_valid_a, rd_empty_a;
  logic [31:0] trig_a;
  logic [255:0] rd_data_a;
  logic [1:0]  state_a;
  logic [3:0]  count_a;

  logic        arm_b, disarm_b, rd_en_b, rd_valid_b, rd_empty_b;
  logic [31:0] trig_b;
  logic [255:0] rd_data_b;
  logic [1:0]  state_b;
  logic [3:0]  count_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] t0, t1, tdummy;

  commit_trace_buffer #(.DEPTH(8), .POST_DEPTH(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
    .commit_instr_i(commit_instr), .commit_rd_i(commit_rd), .commit_we_i(commit_we),
    .commit_wdata_i(commit_wdata), .arm_i(arm_a), .disarm_i(disarm_a), .trig_pc_i(trig_a),
    .rd_en_i(rd_en_a), .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a),
    .rd_empty_o(rd_empty_a), .state_o(state_a), .count_o(count_a)
  );

  commit_trace_buffer #(.DEPTH(8), .POST_DEPTH(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
    .commit_instr_i(commit_instr), .commit_rd_i(commit_rd), .commit_we_i(commit_we),
    .commit_wdata_i(commit_wdata), .arm_i(arm_b), .disarm_i(disarm_b), .trig_pc_i(trig_b),
    .rd_en_i(rd_en_b), .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b),
    .rd_empty_o(rd_empty_b), .state_o(state_b), .count_o(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_instr = pc + 32'h1000_0000;
    commit_rd    = pc[6:2];
    commit_we    = pc[2];
    commit_wdata = pc[2] ? ~pc : 32'hDEAD_BEEF;
    step();
    commit_valid = 1'b0;
  endtask

  function automatic logic [127:0] exp_lo(input logic [31:0] pc);
    logic [127:0] r;
    r = '0;
    r[31:0]    = pc;
    r[63:32]   = pc + 32'h1000_0000;
    r[95:64]   = pc[2] ? ~pc : 32'h0000_0000;
    r[100:96]  = pc[6:2];
    r[WE_BIT]  = pc[2];
    return r;
  endfunction

  task automatic drain(input logic sel, input logic [31:0] pc, output logic [31:0] ts);
    logic [255:0] d;
    logic         v;
    if (sel) rd_en_b = 1'b1; else rd_en_a = 1'b1;
    step();
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    d = sel ? rd_data_b : rd_data_a;
    v = sel ? rd_valid_b : rd_valid_a;
    chk("drain_valid", {255'd0, v}, 256'd1);
    chk("drain_lo", {128'd0, d[127:0]}, {128'd0, exp_lo(pc)});
    chk("drain_hi", {160'd0, d[255:160]}, 256'd0);
    ts = d[TS_LSB +: 32];
  endtask

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_we = 1'b0;
    commit_pc = 32'd0; commit_instr = 32'd0; commit_wdata = 32'd0; commit_rd = 5'd0;
    arm_a = 1'b0; disarm_a = 1'b0; rd_en_a = 1'b0; trig_a = 32'h0000_0020;
    arm_b = 1'b0; disarm_b = 1'b0; rd_en_b = 1'b0; trig_b = 32'h0000_0100;

    // 1: reset
    step(); step();
    chk("rst_state", {254'd0, state_a}, 256'd0);
    chk("rst_count", {252'd0, count_a}, 256'd0);
    chk("rst_empty", {255'd0, rd_empty_a}, 256'd1);
    chk("rst_valid", {255'd0, rd_valid_a}, 256'd0);
    chk("rst_data", rd_data_a, 256'd0);
    rst = 1'b0;

    // 2: arm, rd_en ignored in ARMED, 12 commits with trigger at 0x20
    arm_a = 1'b1; step(); arm_a = 1'b0;
    chk("arm_state", {254'd0, state_a}, 256'd1);
    rd_en_a = 1'b1; step(); rd_en_a = 1'b0;
    chk("armed_rd_ignored", {255'd0, rd_valid_a}, 256'd0);
    for (int i = 0; i < 12; i++) begin
      commit(32'(i * 4));
      if (i == 8) chk("post_state", {254'd0, state_a}, 256'd2);
      if (i == 10) chk("frozen_state", {254'd0, state_a}, 256'd3);
    end
    chk("frozen_count", {252'd0, count_a}, 256'd8);
    commit(32'h0000_0020);
    chk("retrig_state", {254'd0, state_a}, 256'd3);
    chk("retrig_count", {252'd0, count_a}, 256'd8);
    chk("frozen_not_empty", {255'd0, rd_empty_a}, 256'd0);
    for (int i = 0; i < 8; i++) drain(1'b0, 32'(32'h0C + i * 4), tdummy);
    chk("drained_empty", {255'd0, rd_empty_a}, 256'd1);
    rd_en_a = 1'b1; step(); rd_en_a = 1'b0;
    chk("empty_rd_ignored", {255'd0, rd_valid_a}, 256'd0);

    // 4: arm in same cycle as commit 0x40
    arm_a = 1'b1; commit(32'h0000_0040); arm_a = 1'b0;
    chk("arm_commit_count", {252'd0, count_a}, 256'd0);
    commit(32'h0000_0044); commit(32'h0000_0048); commit(32'h0000_0020);
    commit(32'h0000_004C); commit(32'h0000_0050);
    chk("arm2_state", {254'd0, state_a}, 256'd3);
    chk("arm2_count", {252'd0, count_a}, 256'd5);
    drain(1'b0, 32'h0000_0044, tdummy);
    drain(1'b0, 32'h0000_0048, tdummy);
    drain(1'b0, 32'h0000_0020, tdummy);
    drain(1'b0, 32'h0000_004C, tdummy);
    drain(1'b0, 32'h0000_0050, tdummy);
    chk("arm2_empty", {255'd0, rd_empty_a}, 256'd1);

    // 5: reset during POST
    arm_a = 1'b1; step(); arm_a = 1'b0;
    commit(32'h0000_0020);
    chk("pre_rst_post", {254'd0, state_a}, 256'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_state", {254'd0, state_a}, 256'd0);
    chk("mid_rst_count", {252'd0, count_a}, 256'd0);
    chk("mid_rst_empty", {255'd0, rd_empty_a}, 256'd1);

    // disarm keeps count
    arm_a = 1'b1; step(); arm_a = 1'b0;
    commit(32'h0000_0060);
    disarm_a = 1'b1; step(); disarm_a = 1'b0;
    chk("disarm_state", {254'd0, state_a}, 256'd0);
    chk("disarm_count", {252'd0, count_a}, 256'd1);

    // 3: POST_DEPTH=0 instance
    arm_b = 1'b1; step(); arm_b = 1'b0;
    commit(32'h0000_00F8); commit(32'h0000_00FC); commit(32'h0000_0100);
    chk("p0_state", {254'd0, state_b}, 256'd3);
    chk("p0_count", {252'd0, count_b}, 256'd3);
    drain(1'b1, 32'h0000_00F8, tdummy);
    drain(1'b1, 32'h0000_00FC, tdummy);
    drain(1'b1, 32'h0000_0100, tdummy);
    chk("p0_empty", {255'd0, rd_empty_b}, 256'd1);

    // 6: timestamps three cycles apart
    arm_a = 1'b1; step(); arm_a = 1'b0;
    commit(32'h0000_0070); step(); step();
    commit(32'h0000_0074);
    commit(32'h0000_0020); commit(32'h0000_0078); commit(32'h0000_007C);
    chk("ts_frozen", {254'd0, state_a}, 256'd3);
    drain(1'b0, 32'h0000_0070, t0);
    drain(1'b0, 32'h0000_0074, t1);
`ifdef TRACE_TIMESTAMP_EN
    chk("ts_delta", {224'd0, t1 - t0}, 256'd3);
`else
    chk("ts_zero0", {224'd0, t0}, 256'd0);
    chk("ts_zero1", {224'd0, t1}, 256'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
